// File: rtl/sdf_pkg.sv
// Shared definitions for the SDF butterfly stage: width helpers and a complex sample type.
// SDF_SCALE_EN selects halved (WIDTH-bit) outputs instead of WIDTH+1-bit outputs.
package sdf_pkg;

    localparam int SDF_MAX_W = 32;

    function automatic int sdf_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int sdf_ow(input int width);
`ifdef SDF_SCALE_EN
        return width;
`else
        return width + 1;
`endif
    endfunction

    typedef struct packed {
        logic signed [SDF_MAX_W-1:0] re;
        logic signed [SDF_MAX_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/sdf_delay_line.sv
// Complex-sample shift register; dout is the oldest entry (the head).
module sdf_delay_line
    import sdf_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift,
    input  logic [1:0][W-1:0] din,
    output logic [1:0][W-1:0] dout
);
    logic [DEPTH-1:0][1:0][W-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (shift) begin
            for (int i = DEPTH - 1; i > 0; i--) sr[i] <= sr[i-1];
            sr[0] <= din;
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/sdf_bf2_stage.sv
// Radix-2 single-path delay-feedback butterfly stage with self-flush of the last frame.
// Define SDF_SCALE_EN to halve sum/difference and keep outputs at WIDTH bits.
module sdf_bf2_stage
    import sdf_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DELAY = 16,
    localparam int OW    = sdf_ow(WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_in,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    output logic                    ready,
    output logic                    enable_out,
    output logic signed [OW-1:0]    out_re,
    output logic signed [OW-1:0]    out_im,
    output logic                    overrun
);
    localparam int CW = sdf_clog2(2 * DELAY);
    localparam int SW = WIDTH + 1;
    localparam logic [CW-1:0] LAST_P0 = CW'(DELAY - 1);
    localparam logic [CW-1:0] LAST_P1 = CW'(2 * DELAY - 1);

    logic [CW-1:0]          cnt;
    logic                   pend;
    logic                   flushing;
    logic                   advance;
    logic                   phase;
    logic [1:0][WIDTH-1:0]  x;
    logic [1:0][OW-1:0]     head;
    logic [1:0][OW-1:0]     din;
    logic [1:0][OW-1:0]     res;

    assign x       = {in_im, in_re};
    assign phase   = cnt[CW-1];
    assign ready   = ~flushing;
    assign advance = (enable_in & ready) | flushing;

    for (genvar r = 0; r < 2; r++) begin : g_rail
        logic signed [SW-1:0] d_ext;
        logic signed [SW-1:0] x_ext;
        logic [OW-1:0]        sum;
        logic [OW-1:0]        diff;

        assign d_ext = SW'(signed'(head[r]));
        assign x_ext = SW'(signed'(x[r]));
`ifdef SDF_SCALE_EN
        // Full-precision result, then floor-divide by two.
        assign sum  = OW'((d_ext + x_ext) >>> 1);
        assign diff = OW'((d_ext - x_ext) >>> 1);
`else
        assign sum  = OW'(d_ext + x_ext);
        assign diff = OW'(d_ext - x_ext);
`endif
        assign din[r] = phase ? diff : (flushing ? '0 : OW'(x_ext));
        assign res[r] = phase ? sum : head[r];
    end

    sdf_delay_line #(
        .DEPTH(DELAY),
        .W    (OW)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .shift(advance),
        .din  (din),
        .dout (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            pend       <= 1'b0;
            flushing   <= 1'b0;
            overrun    <= 1'b0;
            enable_out <= 1'b0;
            out_re     <= '0;
            out_im     <= '0;
        end else begin
            enable_out <= 1'b0;
            if (enable_in && flushing) overrun <= 1'b1;
            if (!flushing && pend && cnt == '0 && !enable_in) flushing <= 1'b1;
            if (advance) begin
                // A finished flush rewinds to frame start so the next input is sample 0.
                cnt <= (flushing && cnt == LAST_P0) ? '0 : cnt + CW'(1);
                if (phase || pend) begin
                    enable_out <= 1'b1;
                    out_re     <= res[0];
                    out_im     <= res[1];
                end
                if (cnt == LAST_P1) pend <= 1'b1;
                if (cnt == LAST_P0) begin
                    pend     <= 1'b0;
                    flushing <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdf_bf2_stage.sv
// Directed bench for sdf_bf2_stage (WIDTH=8, DELAY=4); expectations scale when SDF_SCALE_EN is set.
module tb_sdf_bf2_stage;
    import sdf_pkg::*;

    localparam int WIDTH = 8;
    localparam int DELAY = 4;
    localparam int OW    = sdf_ow(WIDTH);

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    enable_in;
    logic signed [WIDTH-1:0] in_re;
    logic signed [WIDTH-1:0] in_im;
    logic                    ready;
    logic                    enable_out;
    logic signed [OW-1:0]    out_re;
    logic signed [OW-1:0]    out_im;
    logic                    overrun;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    ready_low;
    cplx_t outq[$];

    always #5 clk = ~clk;

    sdf_bf2_stage #(.WIDTH(WIDTH), .DELAY(DELAY)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable_in (enable_in),
        .in_re     (in_re),
        .in_im     (in_im),
        .ready     (ready),
        .enable_out(enable_out),
        .out_re    (out_re),
        .out_im    (out_im),
        .overrun   (overrun)
    );

    function automatic int sc(input int v);
`ifdef SDF_SCALE_EN
        return v >>> 1;
`else
        return v;
`endif
    endfunction

    task automatic tick();
        cplx_t s;
        @(posedge clk);
        #1;
        if (enable_out) begin
            s.re = SDF_MAX_W'(out_re);
            s.im = SDF_MAX_W'(out_im);
            outq.push_back(s);
        end
        if (!ready) ready_low++;
    endtask

    task automatic drive(input logic en, input int v);
        enable_in = en;
        in_re     = WIDTH'(v);
        in_im     = '0;
        tick();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        enable_in = 1'b0;
        in_re = '0;
        in_im = '0;
        tick();
        rst = 1'b0;
        tick();
        outq.delete();
        ready_low = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable_in = 1'b0;
        in_re = '0;
        in_im = '0;
        #3;
        n_checks++;
        if (enable_out !== 1'b0) begin n_fail++; $display("FAIL reset_enable_out: got %b want 0", enable_out); end
        n_checks++;
        if (out_re !== '0 || out_im !== '0) begin n_fail++; $display("FAIL reset_out: got %0d/%0d want 0/0", out_re, out_im); end
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        int exp[$];
        apply_reset();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, k);
            n_checks++;
            if (enable_out !== (k >= 5)) begin n_fail++; $display("FAIL single_valid_%0d: got %b want %b", k, enable_out, k >= 5); end
            if (k >= 5) begin
                n_checks++;
                if (out_re !== OW'(sc(2 * k - 4))) begin n_fail++; $display("FAIL single_sum_%0d: got %0d want %0d", k, out_re, sc(2 * k - 4)); end
            end
        end
        repeat (8) drive(1'b0, 0);
        for (int k = 5; k <= 8; k++) exp.push_back(sc(2 * k - 4));
        repeat (4) exp.push_back(sc(-4));
        n_checks++;
        if (outq.size() != exp.size()) begin n_fail++; $display("FAIL single_count: got %0d want %0d", outq.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
            n_checks++;
            if (outq[i].re !== exp[i] || outq[i].im !== 0) begin n_fail++; $display("FAIL single_out_%0d: got %0d/%0d want %0d/0", i, outq[i].re, outq[i].im, exp[i]); end
        end
        n_checks++;
        if (ready_low != 4) begin n_fail++; $display("FAIL single_flush_len: got %0d want 4", ready_low); end
        n_checks++;
        if (enable_out !== 1'b0 || out_re !== OW'(sc(-4))) begin n_fail++; $display("FAIL single_idle_hold: got %b/%0d want 0/%0d", enable_out, out_re, sc(-4)); end
    endtask

    task automatic test_back_to_back();
        int exp[$];
        apply_reset();
        for (int f = 0; f < 2; f++)
            for (int k = 1; k <= 8; k++) drive(1'b1, k);
        n_checks++;
        if (ready_low != 0) begin n_fail++; $display("FAIL b2b_ready: got %0d low cycles want 0", ready_low); end
        repeat (8) drive(1'b0, 0);
        for (int f = 0; f < 2; f++) begin
            for (int k = 5; k <= 8; k++) exp.push_back(sc(2 * k - 4));
            repeat (4) exp.push_back(sc(-4));
        end
        n_checks++;
        if (outq.size() != exp.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", outq.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
            n_checks++;
            if (outq[i].re !== exp[i] || outq[i].im !== 0) begin n_fail++; $display("FAIL b2b_out_%0d: got %0d/%0d want %0d/0", i, outq[i].re, outq[i].im, exp[i]); end
        end
        n_checks++;
        if (ready_low != 4) begin n_fail++; $display("FAIL b2b_flush_len: got %0d want 4", ready_low); end
    endtask

    task automatic test_stall();
        int exp[$];
        apply_reset();
        drive(1'b1, 1);
        drive(1'b1, 2);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 0);
            n_checks++;
            if (enable_out !== 1'b0 || ready !== 1'b1 || out_re !== '0) begin n_fail++; $display("FAIL stall_p0_%0d: got v=%b r=%b o=%0d want 0/1/0", i, enable_out, ready, out_re); end
        end
        for (int k = 3; k <= 6; k++) drive(1'b1, k);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 0);
            n_checks++;
            if (enable_out !== 1'b0 || ready !== 1'b1 || out_re !== OW'(sc(8))) begin n_fail++; $display("FAIL stall_p1_%0d: got v=%b r=%b o=%0d want 0/1/%0d", i, enable_out, ready, out_re, sc(8)); end
        end
        drive(1'b1, 7);
        drive(1'b1, 8);
        repeat (8) drive(1'b0, 0);
        for (int k = 5; k <= 8; k++) exp.push_back(sc(2 * k - 4));
        repeat (4) exp.push_back(sc(-4));
        n_checks++;
        if (outq.size() != exp.size()) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", outq.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
            n_checks++;
            if (outq[i].re !== exp[i]) begin n_fail++; $display("FAIL stall_out_%0d: got %0d want %0d", i, outq[i].re, exp[i]); end
        end
    endtask

    task automatic test_overrun();
        int exp[$];
        apply_reset();
        for (int k = 1; k <= 8; k++) drive(1'b1, k);
        drive(1'b0, 0);
        n_checks++;
        if (ready !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pre: got r=%b ovr=%b want 0/0", ready, overrun); end
        drive(1'b1, 99);
        n_checks++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun); end
        repeat (7) drive(1'b0, 0);
        n_checks++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        for (int k = 5; k <= 8; k++) exp.push_back(sc(2 * k - 4));
        repeat (4) exp.push_back(sc(-4));
        n_checks++;
        if (outq.size() != exp.size()) begin n_fail++; $display("FAIL ovr_count: got %0d want %0d", outq.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
            n_checks++;
            if (outq[i].re !== exp[i]) begin n_fail++; $display("FAIL ovr_out_%0d: got %0d want %0d", i, outq[i].re, exp[i]); end
        end
        n_checks++;
        if (ready_low != 4) begin n_fail++; $display("FAIL ovr_flush_len: got %0d want 4", ready_low); end
    endtask

    task automatic test_reset_mid();
        int exp[$];
        apply_reset();
        for (int k = 1; k <= 6; k++) drive(1'b1, k);
        n_checks++;
        if (enable_out !== 1'b1 || out_re !== OW'(sc(8))) begin n_fail++; $display("FAIL rmid_pre: got %b/%0d want 1/%0d", enable_out, out_re, sc(8)); end
        enable_in = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (enable_out !== 1'b0 || out_re !== '0 || out_im !== '0 || ready !== 1'b1) begin n_fail++; $display("FAIL rmid_async: got v=%b o=%0d/%0d r=%b want 0/0/0/1", enable_out, out_re, out_im, ready); end
        tick();
        rst = 1'b0;
        outq.delete();
        ready_low = 0;
        repeat (10) drive(1'b0, 0);
        n_checks++;
        if (outq.size() != 0 || ready_low != 0) begin n_fail++; $display("FAIL rmid_noflush: got %0d outputs, %0d busy want 0/0", outq.size(), ready_low); end
        for (int k = 1; k <= 8; k++) drive(1'b1, k);
        repeat (8) drive(1'b0, 0);
        for (int k = 5; k <= 8; k++) exp.push_back(sc(2 * k - 4));
        repeat (4) exp.push_back(sc(-4));
        n_checks++;
        if (outq.size() != exp.size()) begin n_fail++; $display("FAIL rmid_count: got %0d want %0d", outq.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
            n_checks++;
            if (outq[i].re !== exp[i]) begin n_fail++; $display("FAIL rmid_out_%0d: got %0d want %0d", i, outq[i].re, exp[i]); end
        end
    endtask

    task automatic test_full_scale();
        int exp[$];
        apply_reset();
        repeat (8) drive(1'b1, 127);
        repeat (4) drive(1'b1, 127);
        repeat (4) drive(1'b1, -128);
        repeat (8) drive(1'b0, 0);
        repeat (4) exp.push_back(sc(254));
        repeat (4) exp.push_back(sc(0));
        repeat (4) exp.push_back(sc(-1));
        repeat (4) exp.push_back(sc(255));
        n_checks++;
        if (outq.size() != exp.size()) begin n_fail++; $display("FAIL fs_count: got %0d want %0d", outq.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
            n_checks++;
            if (outq[i].re !== exp[i]) begin n_fail++; $display("FAIL fs_out_%0d: got %0d want %0d", i, outq[i].re, exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall();
        test_overrun();
        test_reset_mid();
        test_full_scale();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdf_bf2_stage.md
SDF_BF2_STAGE -- requirements
Module: sdf_bf2_stage

Interface
REQ-001 Parameter WIDTH, default 8: input sample width, signed two's complement, per rail.
REQ-002 Parameter DELAY, default 16: feedback delay depth in samples; power of two, >=1; frame length = 2*DELAY.
REQ-003 Derived OW: WIDTH+1, or WIDTH when SDF_SCALE_EN is defined.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 enable_in  in  1  input sample valid.
REQ-007 in_re / in_im  in  WIDTH  signed input sample.
REQ-008 ready  out  1  high when enable_in is accepted; low only during self-flush.
REQ-009 enable_out  out  1  output sample valid.
REQ-010 out_re / out_im  out  OW  signed output sample.
REQ-011 overrun  out  1  sticky flag: enable_in asserted while ready=0.

Function
REQ-012 Sample counter cnt is log2(2*DELAY) bits and advances only on an advance cycle; phase = cnt MSB (0: first half, 1: second half); it wraps 2*DELAY-1 -> 0.
REQ-013 Advance = (enable_in & ready) | flushing.
REQ-014 Phase 0 advance: delay line accepts the sign-extended input (zero when flushing); the delay-line head (pending difference) drives the output if pend=1.
REQ-015 Phase 1 advance: with head d and input x, output = d + x; delay line accepts d - x; no saturation, full precision at OW bits.
REQ-016 Delay line shifts only on advance; non-advance cycles hold cnt, delay line, and outputs.
REQ-017 Outputs are registered: enable_out=1 exactly one cycle after an advance that produced a sum (phase 1) or a pending difference (phase 0 with pend=1); otherwise 0.
REQ-018 On non-valid cycles, out_re/out_im hold their last value.
REQ-019 pend is set on the last phase-1 advance (cnt=2*DELAY-1) and cleared on the last phase-0 advance (cnt=DELAY-1).
REQ-020 Flush entry: flushing=1 when pend=1, cnt=0, and enable_in=0; flushing=0 when cnt reaches DELAY.
REQ-021 ready = ~flushing; enable_in while ready=0 is ignored and sets overrun.
REQ-022 Mid-frame enable_in gaps (cnt!=0, not flushing) stall the stage with no data loss.
REQ-023 Back-to-back frames need no flush: next-frame phase-0 inputs carry out the previous differences.

Reset
REQ-024 Async rst clears cnt, pend, flushing, overrun, enable_out, out_re, out_im and all delay-line entries to 0.
REQ-025 Reset mid-frame discards the partial frame; the first advance after release is sample 0.

Configuration
REQ-026 Macro SDF_SCALE_EN defined: OW=WIDTH; sum and difference are computed at WIDTH+1 bits, then arithmetic-shifted right by 1 (truncation toward minus infinity).
REQ-027 SDF_SCALE_EN undefined: OW=WIDTH+1; results are unscaled.

Structure
REQ-028 Shared package sdf_pkg holds: a clog2 function; an OW-derivation function keyed on WIDTH and SDF_SCALE_EN; and a complex-sample typedef {re, im}.
REQ-029 One sub-module, sdf_delay_line: parameters DEPTH and W; ports clk, rst, shift, din, dout (head); shift register of DEPTH complex entries.

Verification (WIDTH=8, DELAY=4, no macro unless stated)
REQ-030 Stimulus: in_re=1..8, in_im=0, contiguous, then enable_in=0.
- Expected sums: enable_out high 1 cycle after inputs 5..8 with re=6,8,10,12.
- Then self-flush: ready=0 for 4 cycles, with re=-4,-4,-4,-4.
- Then enable_out=0.
REQ-031 Stimulus: two contiguous frames, same values.
- ready stays 1 throughout.
- Frame-2 phase-0 outputs are frame-1 differences -4 (x4); frame 2 then flushes.
REQ-032 Stimulus: enable_in low 3 cycles after the 2nd sample.
- cnt, outputs, and enable_out hold.
- Final results match REQ-030 exactly.
REQ-033 Stimulus: enable_in pulsed during flush.
- overrun=1 and stays set; the sample is discarded.
- Flush output is unchanged.
REQ-034 Stimulus: rst asserted after 6 samples.
- All outputs 0 immediately; no flush follows.
- A new frame then produces the correct sums.
REQ-035 Stimulus: SDF_SCALE_EN, in_re=127 for all 8 samples.
- Sums = 127 (254>>>1); differences = 0.
- No overflow at OW=8.
